// File: rtl/adc_spi_pkg.sv
// Shared types and helpers for the MCP320x-style scanning SPI master.
package adc_spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_e;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int frame_bits(input int num_ch, input int lead_bits, input int data_w);
        return 2 + ch_w(num_ch) + lead_bits + data_w;
    endfunction

    // Right-aligned command: start, sgl, then channel MSB first
    function automatic logic [31:0] build_cmd(input logic start_b, input logic sgl_b,
                                              input logic [29:0] ch, input int chw);
        return ({30'd0, start_b, sgl_b} << chw) | {2'b00, ch};
    endfunction

endpackage

// File: rtl/adc_spi_bit_timer.sv
// Half-bit phase timer: free-runs while enabled and strobes phase_end
// on the last cycle of every HALF_BIT-cycle phase.
module adc_spi_bit_timer #(
    parameter int HALF_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic phase_end
);
    localparam int TW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

    logic [TW-1:0] cnt;

    assign phase_end = en && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load || phase_end)
            cnt <= TW'(HALF_BIT - 1);
        else if (en)
            cnt <= cnt - TW'(1);
    end

endmodule

// File: rtl/adc_spi_scan.sv
// SPI master for multi-channel SAR ADCs: single-shot or round-robin scan,
// delivering result, channel tag and a one-cycle dv strobe.
module adc_spi_scan
    import adc_spi_pkg::*;
#(
    parameter int HALF_BIT      = 4,
    parameter int DATA_W        = 12,
    parameter int NUM_CH        = 8,
    parameter int LEAD_BITS     = 2,
    parameter int CS_HIGH       = 4,
    parameter int SAMPLE_PERIOD = 200,
    parameter int SYNC_STAGES   = 2,
    localparam int CH_W         = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              cont_en,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic              cs_n,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              dv,
    output logic              busy,
    output logic              overrun
);
    localparam int CMD_BITS   = 2 + CH_W;
    localparam int FRAME_BITS = frame_bits(NUM_CH, LEAD_BITS, DATA_W);
    localparam int BC_W       = $clog2(FRAME_BITS + 1);
    localparam int PC_W       = $clog2(SAMPLE_PERIOD + 1);
    localparam int HC_W       = $clog2(CS_HIGH + 1);

    state_e                state_q, state_d;
    logic                  phase_end, tmr_load, tmr_en;
    logic [BC_W-1:0]       bit_cnt;
    logic [PC_W-1:0]       per_cnt;
    logic [HC_W-1:0]       hold_cnt;
    logic [CMD_BITS-1:0]   cmd_sr;
    logic [DATA_W-1:0]     shift_sr;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CH_W-1:0]       scan_ch, frame_ch, launch_ch;
    logic                  cont_q, cont_rise, per_hit, cont_req, req, accept;
    logic                  last_bit, hold_done;

    adc_spi_bit_timer #(.HALF_BIT(HALF_BIT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .en        (tmr_en),
        .phase_end (phase_end)
    );

    assign cs_n = !(state_q inside {SETUP, LOW, HIGH});
    assign sclk = (state_q == HIGH);
    assign busy = (state_q != IDLE);
    assign mosi = cmd_sr[CMD_BITS-1];

    always_comb begin
        cont_rise = cont_en && !cont_q;
        per_hit   = cont_en && cont_q && (per_cnt == PC_W'(SAMPLE_PERIOD - 1));
        cont_req  = cont_rise || per_hit;
        // Continuous mode owns the launch path; start only counts when it is off
        req       = cont_req || (start && !cont_en);
        accept    = req && (state_q == IDLE);
        launch_ch = cont_req ? (cont_rise ? '0 : scan_ch) : ch_sel;
        last_bit  = (bit_cnt == BC_W'(FRAME_BITS - 1));
        hold_done = (hold_cnt == HC_W'(CS_HIGH - 1));
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmr_load = 1'b1;
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                tmr_en = 1'b1;
                if (phase_end) state_d = LOW;
            end
            LOW: begin
                tmr_en = 1'b1;
                if (phase_end) state_d = HIGH;
            end
            HIGH: begin
                tmr_en = 1'b1;
                if (phase_end) state_d = last_bit ? HOLD : LOW;
            end
            HOLD: begin
                tmr_load = 1'b1;
                if (hold_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cont_q   <= 1'b0;
            sync_q   <= '0;
            per_cnt  <= '0;
            hold_cnt <= '0;
            bit_cnt  <= '0;
            scan_ch  <= '0;
            frame_ch <= '0;
            cmd_sr   <= '0;
            shift_sr <= '0;
            data_out <= '0;
            data_ch  <= '0;
            dv       <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cont_q   <= cont_en;
            sync_q   <= SYNC_STAGES'({sync_q, miso});
            dv       <= 1'b0;
            overrun  <= req && !accept;
            hold_cnt <= (state_q == HOLD) ? hold_cnt + HC_W'(1) : '0;

            if (cont_rise || !cont_en || per_hit)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + PC_W'(1);

            // Scan channel only advances on frames that actually launched
            if (cont_req && accept)
                scan_ch <= (launch_ch == CH_W'(NUM_CH - 1)) ? '0 : launch_ch + CH_W'(1);
            else if (cont_rise)
                scan_ch <= '0;

            if (accept) begin
                frame_ch <= launch_ch;
                cmd_sr   <= CMD_BITS'(build_cmd(1'b1, 1'b1, 30'(launch_ch), CH_W));
                bit_cnt  <= '0;
            end

            if (state_q == LOW && phase_end)
                shift_sr <= {shift_sr[DATA_W-2:0], sync_q[SYNC_STAGES-1]};

            if (state_q == HIGH && phase_end) begin
                if (last_bit) begin
                    data_out <= shift_sr;
                    data_ch  <= frame_ch;
                    dv       <= 1'b1;
                    cmd_sr   <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BC_W'(1);
                    cmd_sr  <= cmd_sr << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_scan.sv
// Bench for adc_spi_scan: two instances (default and small config) driven by
// behavioural MCP320x models; timing/data expectations from frame arithmetic.
module tb_adc_spi_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic        a_start = 1'b0, a_cont = 1'b0;
    logic [2:0]  a_ch = '0;
    logic [11:0] a_dout;
    logic [2:0]  a_dch;
    logic        a_dv, a_busy, a_ov;
    logic        b_start = 1'b0, b_cont = 1'b0;
    logic        b_ch = 1'b0;
    logic [9:0]  b_dout;
    logic        b_dch, b_dv, b_busy, b_ov;

    wire [1:0] sclk_v, cs_v, mosi_v, miso_v;
    wire [1:0][31:0] last_cmd, cmd_cnt;
    int adc_val [2][8];

    adc_spi_scan u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .ch_sel(a_ch), .cont_en(a_cont),
        .miso(miso_v[0]), .mosi(mosi_v[0]), .sclk(sclk_v[0]), .cs_n(cs_v[0]),
        .data_out(a_dout), .data_ch(a_dch), .dv(a_dv), .busy(a_busy), .overrun(a_ov)
    );

    adc_spi_scan #(
        .HALF_BIT(3), .DATA_W(10), .NUM_CH(2), .LEAD_BITS(1), .CS_HIGH(4),
        .SAMPLE_PERIOD(60), .SYNC_STAGES(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .ch_sel(b_ch), .cont_en(b_cont),
        .miso(miso_v[1]), .mosi(mosi_v[1]), .sclk(sclk_v[1]), .cs_n(cs_v[1]),
        .data_out(b_dout), .data_ch(b_dch), .dv(b_dv), .busy(b_busy), .overrun(b_ov)
    );

    // ADC model: decodes the command on rising sclk, shifts data out after falling sclk
    for (genvar g = 0; g < 2; g++) begin : g_adc
        localparam int CMDB  = (g == 0) ? 5 : 3;
        localparam int LEADB = (g == 0) ? 2 : 1;
        localparam int DWB   = (g == 0) ? 12 : 10;
        localparam int CHM   = (g == 0) ? 7 : 1;
        int idx = 0, cmd = 0, lcmd = 0, ncmd = 0;
        logic ps = 1'b0, mo = 1'b0;
        assign miso_v[g]   = mo;
        assign last_cmd[g] = lcmd;
        assign cmd_cnt[g]  = ncmd;
        always @(negedge clk) begin
            if (cs_v[g]) begin
                idx = 0;
                cmd = 0;
            end else begin
                if (!ps && sclk_v[g] && idx < CMDB) cmd = (cmd << 1) | int'(mosi_v[g]);
                if (ps && !sclk_v[g]) begin
                    idx++;
                    if (idx == CMDB) begin
                        lcmd = cmd;
                        ncmd++;
                    end
                end
            end
            ps = sclk_v[g];
            if (idx >= CMDB + LEADB && idx < CMDB + LEADB + DWB)
                mo = 1'((adc_val[g][cmd & CHM] >> (DWB - 1 - (idx - CMDB - LEADB))) & 1);
            else
                mo = 1'($urandom);
        end
    end

    int a_dv_t[$], a_dv_d[$], a_dv_c[$], a_ov_t[$];
    int b_dv_t[$], b_dv_d[$], b_dv_c[$], b_ov_t[$];
    always @(negedge clk) begin
        if (a_dv === 1'b1) begin
            a_dv_t.push_back(cyc); a_dv_d.push_back(int'(a_dout)); a_dv_c.push_back(int'(a_dch));
        end
        if (a_ov === 1'b1) a_ov_t.push_back(cyc);
        if (b_dv === 1'b1) begin
            b_dv_t.push_back(cyc); b_dv_d.push_back(int'(b_dout)); b_dv_c.push_back(int'(b_dch));
        end
        if (b_ov === 1'b1) b_ov_t.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic int lat(input int h, input int fb);
        return 1 + h + 2 * h * fb;
    endfunction

    task automatic cmp_dv(input string tag, input int g, input int base,
                          input int et[$], input int ec[$], input int ed[$]);
        int n;
        n = ((g == 0) ? a_dv_t.size() : b_dv_t.size()) - base;
        chk({tag, "_n"}, n, et.size());
        for (int i = 0; i < et.size() && i < n; i++) begin
            chk($sformatf("%s_t%0d", tag, i), (g == 0) ? a_dv_t[base+i] : b_dv_t[base+i], et[i]);
            chk($sformatf("%s_c%0d", tag, i), (g == 0) ? a_dv_c[base+i] : b_dv_c[base+i], ec[i]);
            chk($sformatf("%s_d%0d", tag, i), (g == 0) ? a_dv_d[base+i] : b_dv_d[base+i], ed[i]);
        end
    endtask

    task automatic cmp_ov(input string tag, input int g, input int base, input int eo[$]);
        int n;
        n = ((g == 0) ? a_ov_t.size() : b_ov_t.size()) - base;
        chk({tag, "_n"}, n, eo.size());
        for (int i = 0; i < eo.size() && i < n; i++)
            chk($sformatf("%s_o%0d", tag, i), (g == 0) ? a_ov_t[base+i] : b_ov_t[base+i], eo[i]);
    endtask

    // Scan model: requests every sp cycles, accepted only once the previous frame's hold is over
    task automatic build_scan(input int g, input int c, input int stop, input int sp,
                              input int lt, input int blen, input int nch,
                              output int et[$], output int ec[$], output int ed[$], output int eo[$]);
        int free, ch;
        free = 0;
        ch = 0;
        et = {}; ec = {}; ed = {}; eo = {};
        for (int r = c; r < stop; r += sp) begin
            if (r >= free) begin
                et.push_back(r + lt); ec.push_back(ch); ed.push_back(adc_val[g][ch]);
                free = r + blen;
                ch = (ch + 1) % nch;
            end else begin
                eo.push_back(r + 1);
            end
        end
    endtask

    localparam int LAT_A  = 1 + 4 + 2 * 4 * 19;
    localparam int BUSY_A = LAT_A + 4;
    localparam int LAT_B  = 1 + 3 + 2 * 3 * 14;
    localparam int BUSY_B = LAT_B + 4;

    initial begin
        int t, c, ba, bo, nc, ch, v;
        int et[$], ec[$], ed[$], eo[$];
        for (int g = 0; g < 2; g++) for (int k = 0; k < 8; k++) adc_val[g][k] = 0;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_v[0], 1);
        chk("rst_sclk", sclk_v[0], 0);
        chk("rst_mosi", mosi_v[0], 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_dv", a_dv, 0);
        chk("rst_ov", a_ov, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_dch", a_dch, 0);
        chk("rst_b_cs_n", cs_v[1], 1);
        chk("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed single-shot on ch5 with a dropped start mid-frame
        adc_val[0][5] = 'hA5C;
        ba = a_dv_t.size(); bo = a_ov_t.size(); nc = cmd_cnt[0];
        t = cyc; a_ch = 3'd5; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("t1_cs_low", cs_v[0], 0);
        chk("t1_busy", a_busy, 1);
        chk("t1_mosi0", mosi_v[0], 1);
        wait_until(t + 40); a_start = 1'b1; a_ch = 3'd1;
        @(negedge clk); a_start = 1'b0;
        wait_until(t + 159);
        chk("t1_hold_busy", a_busy, 1);
        chk("t1_hold_cs", cs_v[0], 1);
        wait_until(t + 162);
        chk("t1_idle_busy", a_busy, 0);
        wait_until(t + 400);
        et = '{t + LAT_A}; ec = '{5}; ed = '{'hA5C};
        cmp_dv("t1", 0, ba, et, ec, ed);
        eo = '{t + 41};
        cmp_ov("t1", 0, bo, eo);
        chk("t1_cmd", last_cmd[0], 32'b11101);
        chk("t1_ncmd", cmd_cnt[0] - nc, 1);

        // Randomised single shots
        ba = a_dv_t.size();
        et = {}; ec = {}; ed = {};
        for (int i = 0; i < 4; i++) begin
            ch = $urandom_range(0, 7);
            v = $urandom_range(0, 4095);
            adc_val[0][ch] = v;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            t = cyc; a_ch = 3'(ch); a_start = 1'b1;
            @(negedge clk); a_start = 1'b0;
            et.push_back(t + LAT_A); ec.push_back(ch); ed.push_back(v);
            wait_until(t + BUSY_A + 1);
            chk($sformatf("rs_cmd%0d", i), last_cmd[0], 32'(24 + ch));
        end
        cmp_dv("rs", 0, ba, et, ec, ed);

        // Asynchronous reset mid-frame, then a clean frame on ch2
        ba = a_dv_t.size();
        t = cyc; a_ch = 3'd3; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        wait_until(t + 60);
        rst_n = 1'b0;
        #1;
        chk("ar_cs_n", cs_v[0], 1);
        chk("ar_sclk", sclk_v[0], 0);
        chk("ar_busy", a_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_until(t + 200);
        chk("ar_no_dv", a_dv_t.size() - ba, 0);
        v = $urandom_range(0, 4095);
        adc_val[0][2] = v;
        t = cyc; a_ch = 3'd2; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        wait_until(t + BUSY_A + 5);
        et = '{t + LAT_A}; ec = '{2}; ed = '{v};
        cmp_dv("ar", 0, ba, et, ec, ed);

        // Continuous scan (start on the same cycle must be ignored), stop mid-frame
        for (int k = 0; k < 8; k++) adc_val[0][k] = 'h100 + k;
        ba = a_dv_t.size(); bo = a_ov_t.size();
        c = cyc; a_cont = 1'b1; a_start = 1'b1; a_ch = 3'd7;
        @(negedge clk); a_start = 1'b0;
        wait_until(c + 1650); a_cont = 1'b0;
        wait_until(c + 2200);
        build_scan(0, c, c + 1650, 200, LAT_A, BUSY_A, 8, et, ec, ed, eo);
        cmp_dv("sc", 0, ba, et, ec, ed);
        cmp_ov("sc", 0, bo, eo);

        // Small config: period shorter than a frame so every second request overruns
        adc_val[1][0] = 'h2AA;
        adc_val[1][1] = $urandom_range(0, 1023);
        ba = b_dv_t.size(); bo = b_ov_t.size();
        c = cyc; b_cont = 1'b1;
        @(negedge clk);
        wait_until(c + 250); b_cont = 1'b0;
        wait_until(c + 450);
        build_scan(1, c, c + 250, 60, LAT_B, BUSY_B, 2, et, ec, ed, eo);
        cmp_dv("bs", 1, ba, et, ec, ed);
        cmp_ov("bs", 1, bo, eo);

        // Small config single shot
        v = $urandom_range(0, 1023);
        adc_val[1][1] = v;
        ba = b_dv_t.size();
        t = cyc; b_ch = 1'b1; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        wait_until(t + BUSY_B + 5);
        et = '{t + lat(3, 14)}; ec = '{1}; ed = '{v};
        cmp_dv("b1", 1, ba, et, ec, ed);
        chk("b1_cmd", last_cmd[1], 32'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_scan.md
Name: adc_spi_scan

Overview:
Parametrised SPI master for MCP320x/MCP300x-class multi-channel SAR ADCs. It issues a single-ended channel command on mosi and captures a DATA_W-bit result from miso. It supports single-shot conversions on a start strobe and a continuous round-robin scan at a fixed sample period. It feeds the FFT input stage with a data word, a channel tag and a one-cycle dv strobe.

Parameters:
HALF_BIT, 4, clk cycles per SCLK half-period; must satisfy HALF_BIT >= SYNC_STAGES+2
DATA_W, 12, result width in bits
NUM_CH, 8, number of ADC channels; CH_W = max(1, clog2(NUM_CH))
LEAD_BITS, 2, SCLK cycles between the command and the data MSB (sample plus null bit); miso is ignored during them
CS_HIGH, 4, minimum clk cycles cs_n stays high between frames
SAMPLE_PERIOD, 200, clk cycles between frame launches in continuous mode
SYNC_STAGES, 2, miso synchroniser depth

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-shot request; sampled only in IDLE while cont_en=0
ch_sel  in  CH_W  channel for single-shot; captured on start acceptance
cont_en  in  1  continuous scan enable
miso  in  1  ADC data out (asynchronous to clk)
mosi  out  1  command to ADC
sclk  out  1  SPI clock, mode 0 (idle low)
cs_n  out  1  ADC chip select, active low
data_out  out  DATA_W  last conversion result
data_ch  out  CH_W  channel of data_out
dv  out  1  one-cycle pulse when data_out/data_ch update
busy  out  1  high from acceptance until CS_HIGH expires
overrun  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset (asynchronous, any state, mid-frame included): cs_n=1, sclk=0, mosi=0, dv=0, busy=0, overrun=0, data_out=0, data_ch=0, FSM=IDLE, all counters=0, scan channel=0.
- Frame = CMD_BITS (2+CH_W) + LEAD_BITS + DATA_W SCLK cycles = FRAME_BITS. The command is, MSB first: start bit 1, SGL bit 1, channel bits MSB first. Defaults give 5+2+12 = 19.
- FSM states: IDLE -> SETUP -> LOW <-> HIGH -> HOLD -> IDLE.
- Acceptance at cycle t. From edge t+1: cs_n=0, busy=1, mosi=cmd[MSB]. SETUP lasts HALF_BIT cycles with sclk=0.
- Each bit is a LOW phase of HALF_BIT cycles followed by a HIGH phase of HALF_BIT cycles.
- mosi changes only on the cycle sclk goes low (or on entering SETUP).
- The synchronised miso is sampled on the cycle sclk is driven 1 and shifted in MSB first. Only the final DATA_W samples are kept.
- Frame end is edge t+1+HALF_BIT+2*HALF_BIT*FRAME_BITS; defaults give t+157. On that cycle: sclk=0, cs_n=1, mosi=0, data_out and data_ch load, dv=1 for exactly one cycle.
- HOLD keeps busy=1 and cs_n=1 for CS_HIGH cycles, then returns to IDLE with busy=0. The earliest next acceptance is on the IDLE cycle.
- Single-shot: start is ignored when cont_en=1. If start=1 while busy=1 and cont_en=0, overrun pulses and the request is dropped; the frame in progress is unaffected.
- Continuous:
  - A cont_en 0->1 transition resets the scan channel to 0 and the period counter to 0, and launches a frame on the next cycle.
  - Afterwards a launch request fires every SAMPLE_PERIOD cycles.
  - The scan channel increments after each launched frame and wraps NUM_CH-1 -> 0.
  - If a request fires while busy, overrun pulses, the request is skipped and the channel does not advance.
- cont_en falling mid-frame: the current frame completes normally and no further launches occur.
- start and the cont_en rise on the same cycle: continuous mode wins and start is ignored.
- Period counter width is clog2(SAMPLE_PERIOD+1); it wraps to 0 at SAMPLE_PERIOD-1.

Decomposition:
- Package adc_spi_pkg holds:
  - the state enum (IDLE, SETUP, LOW, HIGH, HOLD);
  - the CH_W and FRAME_BITS localparam functions;
  - the command-word builder function (start, sgl, channel).
- One sub-module, adc_spi_bit_timer: half-bit down-counter with load and enable. It produces the phase-end strobe that the FSM uses for all sclk transitions.
- The miso synchroniser and shift register stay inline.

Test Plan:
- Defaults, ADC model returns 12'hA5C on ch5; start with ch_sel=5 at t -> mosi bits 1,1,1,0,1; dv exactly at t+157; data_out=12'hA5C; data_ch=5; busy low at t+162.
- start pulsed at t+40 during that frame -> overrun one-cycle pulse at t+41; single dv; no second frame.
- cont_en=1, SAMPLE_PERIOD=200, model returns 12'h100+ch -> dv every 200 cycles with data_ch 0,1,...,7,0 and data_out 12'h100..12'h107,12'h100.
- Continuous with SAMPLE_PERIOD=100 -> every second request raises overrun; channels advance 0,1,2 only on launched frames.
- rst_n low at t+60 mid-frame -> cs_n=1, sclk=0, busy=0 immediately (asynchronous); no dv. After release, start ch2 -> correct frame.
- NUM_CH=2, DATA_W=10, LEAD_BITS=1, HALF_BIT=3 -> FRAME_BITS=14; dv at t+1+3+84=t+88; 10-bit value 10'h2AA captured exactly.
